lc3_control_fsm: RTL and testbench

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

---
 rtl/lc3_control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// LC-3 datapath control: Moore FSM with registered outputs; fetch 5 cycles, instructions 6-9 cycles total.
// Optional PAUSE instruction (opcode 1101) is compiled in only when LC3_PAUSE_EN is defined.
module lc3_control_fsm (
   input  logic       Clk,
   input  logic       Reset_al,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       ADDR1MUX,
   output logic       SR1MUX,
   output logic       DRMUX,
   output logic       MIO_EN,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   typedef enum logic [4:0] {
      HALTED, S18, S33_1, S33_2, S35, S32,
      S01, S05, S09, S00, S22, S12, S04, S21,
      S06, S25_1, S25_2, S27, S07, S23, S16_1, S16_2,
      PAUSE1, PAUSE2
   } state_t;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_cc;
      logic       ld_reg;
      logic       ld_pc;
      logic       ld_led;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       addr1mux;
      logic       sr1mux;
      logic       drmux;
      logic       mio_en;
      logic       mem_oe;
      logic       mem_we;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};

   state_t r_state;
   state_t w_state_nxt;
   ctrl_t  r_ctrl;
   ctrl_t  w_ctrl_nxt;

   // IR_5 steers the SR2 mux directly in the datapath; the FSM never needs it.
   logic w_unused_ir5;
   assign w_unused_ir5 = IR_5;
`ifndef LC3_PAUSE_EN
   logic w_unused_continue;
   assign w_unused_continue = Continue;
`endif

   // Outputs are precomputed from the next state so each state's controls are registered.
   function automatic ctrl_t ctrl_for(input state_t s, input logic ir11);
      ctrl_t c;
      c = CTRL_IDLE;
      case (s)
         S18: begin
            c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
         end
         S33_1, S25_1: begin
            c.mem_oe = 1'b0; c.mio_en = 1'b1;
         end
         S33_2, S25_2: begin
            c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = 1'b1;
         end
         S35: begin
            c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
         end
         S32: c.ld_ben = 1'b1;
         S01, S05, S09: begin
            c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            c.aluk = (s == S05) ? 2'b01 : ((s == S09) ? 2'b10 : 2'b00);
         end
         S22: begin
            c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.pcmux = 2'b01; c.ld_pc = 1'b1;
         end
         S12: begin
            c.sr1mux = 1'b1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1'b1;
         end
         S04: begin
            c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
         end
         S21: begin
            c.pcmux = 2'b01; c.ld_pc = 1'b1;
            if (ir11) begin
               c.addr1mux = 1'b1; c.addr2mux = 2'b00;
            end else begin
               c.sr1mux = 1'b1; c.addr2mux = 2'b11;
            end
         end
         S06, S07: begin
            c.sr1mux = 1'b1; c.addr2mux = 2'b10; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
         end
         S27: begin
            c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
         end
         S23: begin
            c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
         end
         S16_1, S16_2: c.mem_we = 1'b0;
`ifdef LC3_PAUSE_EN
         PAUSE1: c.ld_led = 1'b1;
`endif
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      w_state_nxt = S18;
      case (r_state)
         HALTED: w_state_nxt = Run ? S18 : HALTED;
         S18:    w_state_nxt = S33_1;
         S33_1:  w_state_nxt = S33_2;
         S33_2:  w_state_nxt = S35;
         S35:    w_state_nxt = S32;
         S32: begin
            case (Opcode)
               4'b0001: w_state_nxt = S01;
               4'b0101: w_state_nxt = S05;
               4'b1001: w_state_nxt = S09;
               4'b0000: w_state_nxt = S00;
               4'b1100: w_state_nxt = S12;
               4'b0100: w_state_nxt = S04;
               4'b0110: w_state_nxt = S06;
               4'b0111: w_state_nxt = S07;
`ifdef LC3_PAUSE_EN
               4'b1101: w_state_nxt = PAUSE1;
`endif
               default: w_state_nxt = S18;
            endcase
         end
         S00:    w_state_nxt = BEN ? S22 : S18;
         S04:    w_state_nxt = S21;
         S06:    w_state_nxt = S25_1;
         S25_1:  w_state_nxt = S25_2;
         S25_2:  w_state_nxt = S27;
         S07:    w_state_nxt = S23;
         S23:    w_state_nxt = S16_1;
         S16_1:  w_state_nxt = S16_2;
`ifdef LC3_PAUSE_EN
         PAUSE1: w_state_nxt = Continue ? PAUSE2 : PAUSE1;
         PAUSE2: w_state_nxt = Continue ? PAUSE2 : S18;
`endif
         default: w_state_nxt = S18;
      endcase
   end

   always_comb begin
      w_ctrl_nxt = ctrl_for(w_state_nxt, IR_11);
   end

   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         r_state <= HALTED;
         r_ctrl  <= CTRL_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_ctrl  <= w_ctrl_nxt;
      end
   end

   assign LD_MAR     = r_ctrl.ld_mar;
   assign LD_MDR     = r_ctrl.ld_mdr;
   assign LD_IR      = r_ctrl.ld_ir;
   assign LD_BEN     = r_ctrl.ld_ben;
   assign LD_CC      = r_ctrl.ld_cc;
   assign LD_REG     = r_ctrl.ld_reg;
   assign LD_PC      = r_ctrl.ld_pc;
   assign LD_LED     = r_ctrl.ld_led;
   assign GatePC     = r_ctrl.gate_pc;
   assign GateMDR    = r_ctrl.gate_mdr;
   assign GateALU    = r_ctrl.gate_alu;
   assign GateMARMUX = r_ctrl.gate_marmux;
   assign PCMUX      = r_ctrl.pcmux;
   assign ADDR2MUX   = r_ctrl.addr2mux;
   assign ALUK       = r_ctrl.aluk;
   assign ADDR1MUX   = r_ctrl.addr1mux;
   assign SR1MUX     = r_ctrl.sr1mux;
   assign DRMUX      = r_ctrl.drmux;
   assign MIO_EN     = r_ctrl.mio_en;
   assign Mem_OE     = r_ctrl.mem_oe;
   assign Mem_WE     = r_ctrl.mem_we;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed vector bench for lc3_control_fsm; the PAUSE rows follow LC3_PAUSE_EN.
module tb_lc3_control_fsm;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_cc;
      logic       ld_reg;
      logic       ld_pc;
      logic       ld_led;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       addr1mux;
      logic       sr1mux;
      logic       drmux;
      logic       mio_en;
      logic       mem_oe;
      logic       mem_we;
   } o_t;

   typedef struct {
      logic       run;
      logic       cont;
      logic [3:0] op;
      logic       ben;
      logic       ir11;
      o_t         exp;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset_al = 1'b0;
   logic       Run = 1'b0;
   logic       Continue = 1'b0;
   logic [3:0] Opcode = 4'b0000;
   logic       IR_5 = 1'b0;
   logic       IR_11 = 1'b0;
   logic       BEN = 1'b0;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic       ADDR1MUX, SR1MUX, DRMUX, MIO_EN, Mem_OE, Mem_WE;

   int checks = 0;
   int failures = 0;
   vec_t vq[$];
   o_t act;

   lc3_control_fsm dut (
      .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .DRMUX(DRMUX), .MIO_EN(MIO_EN),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      act = '0;
      act.ld_mar = LD_MAR;   act.ld_mdr = LD_MDR;     act.ld_ir = LD_IR;       act.ld_ben = LD_BEN;
      act.ld_cc = LD_CC;     act.ld_reg = LD_REG;     act.ld_pc = LD_PC;       act.ld_led = LD_LED;
      act.gate_pc = GatePC;  act.gate_mdr = GateMDR;  act.gate_alu = GateALU;  act.gate_marmux = GateMARMUX;
      act.pcmux = PCMUX;     act.addr2mux = ADDR2MUX; act.aluk = ALUK;
      act.addr1mux = ADDR1MUX; act.sr1mux = SR1MUX;   act.drmux = DRMUX;       act.mio_en = MIO_EN;
      act.mem_oe = Mem_OE;   act.mem_we = Mem_WE;
   end

   // Expected control words, written out from the state tables.
   function automatic o_t e_idle();
      o_t o = '0;
      o.mem_oe = 1'b1; o.mem_we = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s18();
      o_t o = e_idle();
      o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.pcmux = 2'b10; o.ld_pc = 1'b1;
      return o;
   endfunction
   function automatic o_t e_rd(input logic second);
      o_t o = e_idle();
      o.mem_oe = 1'b0; o.mio_en = 1'b1; o.ld_mdr = second;
      return o;
   endfunction
   function automatic o_t e_s35();
      o_t o = e_idle();
      o.gate_mdr = 1'b1; o.ld_ir = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s32();
      o_t o = e_idle();
      o.ld_ben = 1'b1;
      return o;
   endfunction
   function automatic o_t e_alu(input logic [1:0] k);
      o_t o = e_idle();
      o.sr1mux = 1'b1; o.aluk = k; o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s22();
      o_t o = e_idle();
      o.addr1mux = 1'b1; o.addr2mux = 2'b01; o.pcmux = 2'b01; o.ld_pc = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s12();
      o_t o = e_idle();
      o.sr1mux = 1'b1; o.addr2mux = 2'b11; o.pcmux = 2'b01; o.ld_pc = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s04();
      o_t o = e_idle();
      o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s21(input logic ir11);
      o_t o = e_idle();
      o.pcmux = 2'b01; o.ld_pc = 1'b1;
      if (ir11) begin o.addr1mux = 1'b1; o.addr2mux = 2'b00; end
      else begin o.sr1mux = 1'b1; o.addr2mux = 2'b11; end
      return o;
   endfunction
   function automatic o_t e_s06();
      o_t o = e_idle();
      o.sr1mux = 1'b1; o.addr2mux = 2'b10; o.gate_marmux = 1'b1; o.ld_mar = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s27();
      o_t o = e_idle();
      o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s23();
      o_t o = e_idle();
      o.aluk = 2'b11; o.gate_alu = 1'b1; o.ld_mdr = 1'b1;
      return o;
   endfunction
   function automatic o_t e_s16();
      o_t o = e_idle();
      o.mem_we = 1'b0;
      return o;
   endfunction
   function automatic o_t e_p1();
      o_t o = e_idle();
      o.ld_led = 1'b1;
      return o;
   endfunction

   task automatic push(input logic run, input logic cont, input logic [3:0] op,
                       input logic ben, input logic ir11, input o_t e);
      vec_t v;
      v.run = run; v.cont = cont; v.op = op; v.ben = ben; v.ir11 = ir11; v.exp = e;
      vq.push_back(v);
   endtask

   // Rows for S33_1, S33_2, S35, S32 with the given inputs held.
   task automatic fetch(input logic run, input logic cont, input logic [3:0] op,
                        input logic ben, input logic ir11);
      push(run, cont, op, ben, ir11, e_rd(1'b0));
      push(run, cont, op, ben, ir11, e_rd(1'b1));
      push(run, cont, op, ben, ir11, e_s35());
      push(run, cont, op, ben, ir11, e_s32());
   endtask

   task automatic check(input string name, input o_t exp);
      checks++;
      if (act !== exp || (act.mem_oe === 1'b0 && act.mem_we === 1'b0)) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic run, input logic cont, input logic [3:0] op,
                       input logic ben, input logic ir11);
      @(negedge Clk);
      Run = run; Continue = cont; Opcode = op; BEN = ben; IR_11 = ir11;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Halted holds until Run, then a full pass through each instruction type.
      push(0, 0, 4'b0000, 0, 0, e_idle());
      push(1, 0, 4'b0000, 0, 0, e_s18());
      fetch(1, 1, 4'b0001, 0, 0);
      push(1, 1, 4'b0001, 0, 0, e_alu(2'b00));
      push(1, 1, 4'b0001, 0, 0, e_s18());
      fetch(0, 0, 4'b0101, 0, 0);
      push(0, 0, 4'b0101, 0, 0, e_alu(2'b01));
      push(0, 0, 4'b0101, 0, 0, e_s18());
      fetch(0, 0, 4'b1001, 0, 0);
      push(0, 0, 4'b1001, 0, 0, e_alu(2'b10));
      push(0, 0, 4'b1001, 0, 0, e_s18());
      fetch(0, 0, 4'b0000, 0, 0);
      push(0, 0, 4'b0000, 0, 0, e_idle());
      push(0, 0, 4'b0000, 0, 0, e_s18());
      fetch(0, 0, 4'b0000, 1, 0);
      push(0, 0, 4'b0000, 1, 0, e_idle());
      push(0, 0, 4'b0000, 1, 0, e_s22());
      push(0, 0, 4'b0000, 1, 0, e_s18());
      fetch(0, 0, 4'b1100, 0, 0);
      push(0, 0, 4'b1100, 0, 0, e_s12());
      push(0, 0, 4'b1100, 0, 0, e_s18());
      fetch(0, 0, 4'b0100, 0, 1);
      push(0, 0, 4'b0100, 0, 1, e_s04());
      push(0, 0, 4'b0100, 0, 1, e_s21(1'b1));
      push(0, 0, 4'b0100, 0, 1, e_s18());
      fetch(0, 0, 4'b0100, 0, 0);
      push(0, 0, 4'b0100, 0, 0, e_s04());
      push(0, 0, 4'b0100, 0, 0, e_s21(1'b0));
      push(0, 0, 4'b0100, 0, 0, e_s18());
      fetch(0, 0, 4'b0110, 0, 0);
      push(0, 0, 4'b0110, 0, 0, e_s06());
      push(0, 0, 4'b0110, 0, 0, e_rd(1'b0));
      push(0, 0, 4'b0110, 0, 0, e_rd(1'b1));
      push(0, 0, 4'b0110, 0, 0, e_s27());
      push(0, 0, 4'b0110, 0, 0, e_s18());
      fetch(0, 0, 4'b0111, 0, 0);
      push(0, 0, 4'b0111, 0, 0, e_s06());
      push(0, 0, 4'b0111, 0, 0, e_s23());
      push(0, 0, 4'b0111, 0, 0, e_s16());
      push(0, 0, 4'b0111, 0, 0, e_s16());
      push(0, 0, 4'b0111, 0, 0, e_s18());
      fetch(0, 0, 4'b1101, 0, 0);
`ifdef LC3_PAUSE_EN
      push(0, 0, 4'b1101, 0, 0, e_p1());
      push(1, 0, 4'b1101, 0, 0, e_p1());
      push(0, 1, 4'b1101, 0, 0, e_idle());
      push(0, 1, 4'b1101, 0, 0, e_idle());
      push(0, 0, 4'b1101, 0, 0, e_s18());
`else
      push(0, 1, 4'b1101, 0, 0, e_s18());
`endif
      fetch(0, 0, 4'b0011, 0, 0);
      push(0, 0, 4'b0011, 0, 0, e_s18());

      // Reset with Run high must still land in Halted with idle strobes.
      Run = 1'b1;
      repeat (2) @(posedge Clk);
      #1 check("reset_state", e_idle());
      @(negedge Clk);
      Run = 1'b0;
      Reset_al = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].run, vq[i].cont, vq[i].op, vq[i].ben, vq[i].ir11);
         check($sformatf("vec%0d", i), vq[i].exp);
      end

      // Reset mid-read: strobes must drop before the next edge.
      for (int i = 0; i < 5; i++) step(0, 0, 4'b0110, 0, 0);
      step(0, 0, 4'b0110, 0, 0);
      check("ldr_s25_1", e_rd(1'b0));
      #2 Reset_al = 1'b0;
      #1 check("reset_mid_read", e_idle());
      @(posedge Clk);
      #1 check("reset_held", e_idle());
      @(negedge Clk);
      Reset_al = 1'b1;
      step(0, 0, 4'b0110, 0, 0);
      check("halted_after_release", e_idle());
      step(0, 0, 4'b0110, 0, 0);
      check("halted_no_run", e_idle());
      step(1, 0, 4'b0110, 0, 0);
      check("run_to_s18", e_s18());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
